// File: rtl/fifo_sync_circular_if.sv
//==============================================================================
// Module      : fifo_sync_circular_if
// Description : Producer/consumer bundle for the single-clock circular FIFO.
//               The master side drives requests and observes data and status.
//               The slave side is the FIFO itself.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface fifo_sync_circular_if #(
  parameter int WIDTH     = 8,
  parameter int PTR_WIDTH = 3
);
  logic                 write_in;
  logic [WIDTH-1:0]     wdata_in;
  logic                 read_in;
  logic                 clear_err_in;
  logic [WIDTH-1:0]     rdata_out;
  logic                 rvalid_out;
  logic                 full_out;
  logic                 empty_out;
  logic                 afull_out;
  logic                 aempty_out;
  logic [PTR_WIDTH-1:0] count_out;
  logic                 overflow_out;
  logic                 underflow_out;

  modport master (
    output write_in, wdata_in, read_in, clear_err_in,
    input  rdata_out, rvalid_out, full_out, empty_out, afull_out, aempty_out,
           count_out, overflow_out, underflow_out
  );

  modport slave (
    input  write_in, wdata_in, read_in, clear_err_in,
    output rdata_out, rvalid_out, full_out, empty_out, afull_out, aempty_out,
           count_out, overflow_out, underflow_out
  );
endinterface

`default_nettype wire

// File: rtl/fifo_sync_circular.sv
//==============================================================================
// Module      : fifo_sync_circular
// Description : Single-clock circular FIFO with binary wrap-bit pointers,
//               registered full/empty/almost flags, fill level and sticky
//               overflow/underflow flags. Read data has one cycle of latency.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module fifo_sync_circular #(
  parameter int WIDTH        = 8,
  parameter int PTR_WIDTH    = 3,
  parameter int AFULL_LEVEL  = 3,
  parameter int AEMPTY_LEVEL = 1
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  fifo_sync_circular_if.slave   bus
);

  localparam int ADDR_WIDTH = PTR_WIDTH - 1;
  localparam int DEPTH      = 2 ** ADDR_WIDTH;
  // Thresholds sized to the pointer width; DEPTH always fits in PTR_WIDTH bits.
  localparam logic [PTR_WIDTH-1:0] AFULL_THR  = PTR_WIDTH'(AFULL_LEVEL);
  localparam logic [PTR_WIDTH-1:0] AEMPTY_THR = PTR_WIDTH'(AEMPTY_LEVEL);

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [PTR_WIDTH-1:0] wptr;
  logic [PTR_WIDTH-1:0] rptr;
  logic [PTR_WIDTH-1:0] wptr_next;
  logic [PTR_WIDTH-1:0] rptr_next;
  logic [PTR_WIDTH-1:0] count_next;
  logic                 wr_acc;
  logic                 rd_acc;
  logic                 full_next;
  logic                 empty_next;

  // Accept decisions use only registered flags, so no input reaches an output
  // combinationally; next flags come from the post-access pointers.
  always_comb begin
    wr_acc     = bus.write_in & ~bus.full_out;
    rd_acc     = bus.read_in  & ~bus.empty_out;
    wptr_next  = wr_acc ? wptr + 1'b1 : wptr;
    rptr_next  = rd_acc ? rptr + 1'b1 : rptr;
    count_next = wptr_next - rptr_next;
    empty_next = (wptr_next == rptr_next);
    full_next  = (wptr_next[ADDR_WIDTH-1:0] == rptr_next[ADDR_WIDTH-1:0]) &&
                 (wptr_next[PTR_WIDTH-1] != rptr_next[PTR_WIDTH-1]);
  end

  // Storage array; contents are intentionally left unreset.
  always_ff @(posedge clk_in) begin
    if (!rst_in && wr_acc) begin
      mem[wptr[ADDR_WIDTH-1:0]] <= bus.wdata_in;
    end
  end

  // Pointers, read data and all status registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wptr              <= '0;
      rptr              <= '0;
      bus.rdata_out     <= '0;
      bus.rvalid_out    <= 1'b0;
      bus.full_out      <= 1'b0;
      bus.empty_out     <= 1'b1;
      bus.afull_out     <= 1'b0;
      bus.aempty_out    <= 1'b1;
      bus.count_out     <= '0;
      bus.overflow_out  <= 1'b0;
      bus.underflow_out <= 1'b0;
    end else begin
      wptr           <= wptr_next;
      rptr           <= rptr_next;
      bus.rvalid_out <= rd_acc;
      if (rd_acc) begin
        bus.rdata_out <= mem[rptr[ADDR_WIDTH-1:0]];
      end
      bus.full_out   <= full_next;
      bus.empty_out  <= empty_next;
      bus.afull_out  <= (count_next >= AFULL_THR);
      bus.aempty_out <= (count_next <= AEMPTY_THR);
      bus.count_out  <= count_next;
      // A new error event in the same cycle as a clear keeps the flag set.
      bus.overflow_out  <= (bus.write_in & bus.full_out) |
                           (bus.overflow_out & ~bus.clear_err_in);
      bus.underflow_out <= (bus.read_in & bus.empty_out) |
                           (bus.underflow_out & ~bus.clear_err_in);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_sync_circular.sv
//==============================================================================
// Module      : tb_fifo_sync_circular
// Description : Self-checking bench for fifo_sync_circular using a queue-based
//               reference model, directed scenarios and randomized traffic.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_fifo_sync_circular;

  localparam int WIDTH        = 8;
  localparam int PTR_WIDTH    = 3;
  localparam int DEPTH        = 4;
  localparam int AFULL_LEVEL  = 3;
  localparam int AEMPTY_LEVEL = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   errors  = 0;

  fifo_sync_circular_if #(.WIDTH(WIDTH), .PTR_WIDTH(PTR_WIDTH)) bus ();

  fifo_sync_circular #(
    .WIDTH(WIDTH), .PTR_WIDTH(PTR_WIDTH),
    .AFULL_LEVEL(AFULL_LEVEL), .AEMPTY_LEVEL(AEMPTY_LEVEL)
  ) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Reference model: the FIFO contents as a queue plus the output registers.
  logic [7:0] q[$];
  logic [7:0] m_rdata;
  bit         m_rvalid, m_ovf, m_udf;

  // Status layout: {full, empty, afull, aempty, count[2:0], ovf, udf, rvalid}
  localparam logic [9:0] RESET_STATUS = 10'b0_1_0_1_000_0_0_0;

  function automatic logic [9:0] exp_status();
    int n = q.size();
    return {n == DEPTH, n == 0, n >= AFULL_LEVEL, n <= AEMPTY_LEVEL,
            3'(n), m_ovf, m_udf, m_rvalid};
  endfunction

  function automatic logic [9:0] dut_status();
    return {bus.full_out, bus.empty_out, bus.afull_out, bus.aempty_out,
            bus.count_out, bus.overflow_out, bus.underflow_out, bus.rvalid_out};
  endfunction

  // Apply one clock of stimulus, advance the model, and settle 1 time unit past the edge.
  task automatic cycle(input bit w, input logic [7:0] d, input bit r,
                       input bit c = 1'b0, input bit rs = 1'b0);
    bit wa, ra, was_full, was_empty;
    bus.write_in     = w;
    bus.wdata_in     = d;
    bus.read_in      = r;
    bus.clear_err_in = c;
    rst              = rs;
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    wa = w && !was_full;
    ra = r && !was_empty;
    @(posedge clk);
    if (rs) begin
      q.delete();
      m_rdata = '0; m_rvalid = 0; m_ovf = 0; m_udf = 0;
    end else begin
      m_rvalid = ra;
      if (ra) m_rdata = q.pop_front();
      if (wa) q.push_back(d);
      m_ovf = (w && was_full)  || (m_ovf && !c);
      m_udf = (r && was_empty) || (m_udf && !c);
    end
    #1;
    bus.write_in = 0; bus.read_in = 0; bus.clear_err_in = 0; rst = 0;
  endtask

  task automatic test_reset();
    cycle(0, 8'h00, 0, 0, 1);
    cycle(0, 8'h00, 0, 0, 1);
    cycle(0, 8'h00, 0);
    vectors++;
    if (dut_status() !== RESET_STATUS) begin
      errors++;
      $display("FAIL reset_status: got %b want %b", dut_status(), RESET_STATUS);
    end
    vectors++;
    if (bus.rdata_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_rdata: got %h want 00", bus.rdata_out);
    end
  endtask

  task automatic test_fill_drain();
    logic [7:0] words[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [9:0] want[4]  = '{10'b0_0_0_1_001_0_0_0, 10'b0_0_0_0_010_0_0_0,
                             10'b0_0_1_0_011_0_0_0, 10'b1_0_1_0_100_0_0_0};
    for (int i = 0; i < 4; i++) begin
      cycle(1, words[i], 0);
      vectors++;
      if (dut_status() !== want[i]) begin
        errors++;
        $display("FAIL fill_status[%0d]: got %b want %b", i, dut_status(), want[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      cycle(0, 8'h00, 1);
      vectors++;
      if (bus.rdata_out !== words[i] || bus.rvalid_out !== 1'b1) begin
        errors++;
        $display("FAIL drain_data[%0d]: got %h/%b want %h/1", i, bus.rdata_out,
                 bus.rvalid_out, words[i]);
      end
    end
    vectors++;
    if (bus.empty_out !== 1'b1 || bus.count_out !== 3'd0) begin
      errors++;
      $display("FAIL drain_empty: got empty=%b count=%0d want 1/0", bus.empty_out,
               bus.count_out);
    end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 4; i++) cycle(1, 8'(i * 8'h11), 0);
    cycle(1, 8'h55, 0);
    vectors++;
    if (bus.overflow_out !== 1'b1 || bus.count_out !== 3'd4 || bus.full_out !== 1'b1) begin
      errors++;
      $display("FAIL overflow_set: got ovf=%b count=%0d full=%b want 1/4/1",
               bus.overflow_out, bus.count_out, bus.full_out);
    end
    cycle(0, 8'h00, 0);
    vectors++;
    if (bus.overflow_out !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky: got %b want 1", bus.overflow_out);
    end
    for (int i = 1; i <= 4; i++) begin
      cycle(0, 8'h00, 1);
      vectors++;
      if (bus.rdata_out !== 8'(i * 8'h11)) begin
        errors++;
        $display("FAIL overflow_data[%0d]: got %h want %h", i, bus.rdata_out, 8'(i * 8'h11));
      end
    end
    cycle(0, 8'h00, 0, 1);
    vectors++;
    if (bus.overflow_out !== 1'b0) begin
      errors++;
      $display("FAIL overflow_clear: got %b want 0", bus.overflow_out);
    end
  endtask

  task automatic test_underflow_simul();
    cycle(1, 8'hA5, 1);
    vectors++;
    if (bus.underflow_out !== 1'b1 || bus.count_out !== 3'd1 || bus.rvalid_out !== 1'b0) begin
      errors++;
      $display("FAIL underflow_simul: got udf=%b count=%0d rvalid=%b want 1/1/0",
               bus.underflow_out, bus.count_out, bus.rvalid_out);
    end
    cycle(0, 8'h00, 1);
    vectors++;
    if (bus.rdata_out !== 8'hA5 || bus.rvalid_out !== 1'b1) begin
      errors++;
      $display("FAIL underflow_readback: got %h/%b want a5/1", bus.rdata_out, bus.rvalid_out);
    end
    cycle(0, 8'h00, 0, 1);
    vectors++;
    if (bus.underflow_out !== 1'b0) begin
      errors++;
      $display("FAIL underflow_clear: got %b want 0", bus.underflow_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq[10] = '{8'hC1, 8'hC2, 8'h00, 8'h01, 8'h02, 8'h03,
                            8'h04, 8'h05, 8'h06, 8'h07};
    cycle(1, 8'hC1, 0);
    cycle(1, 8'hC2, 0);
    for (int i = 0; i < 10; i++) begin
      cycle(1, 8'(i), 1);
      vectors++;
      if (bus.rdata_out !== seq[i] || dut_status() !== 10'b0_0_0_0_010_0_0_1) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got %h/%b want %h/%b", i, bus.rdata_out,
                 dut_status(), seq[i], 10'b0_0_0_0_010_0_0_1);
      end
    end
    cycle(0, 8'h00, 1);
    cycle(0, 8'h00, 1);
  endtask

  task automatic test_reset_mid();
    cycle(1, 8'h71, 0);
    cycle(1, 8'h72, 0);
    cycle(1, 8'h73, 0);
    cycle(0, 8'h00, 1, 0, 1);
    vectors++;
    if (dut_status() !== RESET_STATUS || bus.rdata_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid: got %b/%h want %b/00", dut_status(), bus.rdata_out,
               RESET_STATUS);
    end
    cycle(1, 8'h3C, 0);
    cycle(0, 8'h00, 1);
    vectors++;
    if (bus.rdata_out !== 8'h3C || bus.empty_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_roundtrip: got %h empty=%b want 3c/1", bus.rdata_out,
               bus.empty_out);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 99) < 55), 8'($urandom), 1'($urandom_range(0, 99) < 45),
            1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 99) == 0));
      vectors++;
      if (dut_status() !== exp_status() || bus.rdata_out !== m_rdata) begin
        errors++;
        $display("FAIL random[%0d]: got %b/%h want %b/%h", i, dut_status(),
                 bus.rdata_out, exp_status(), m_rdata);
      end
    end
  endtask

  initial begin
    bus.write_in = 0; bus.wdata_in = '0; bus.read_in = 0; bus.clear_err_in = 0;
    m_rdata = '0; m_rvalid = 0; m_ovf = 0; m_udf = 0;
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow_simul();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
